toggle_activity_counter: RTL and testbench

- Consumer side of the gate-level stimulus flow. Benches drive input vectors into a DUT and dump activity. This block samples a bus of monitored nets and counts per-net transitions over a programmable window.
- It then streams the per-net toggle counts out over a valid/ready interface to the power-estimation datapath.
- It is the hardware equivalent of reading the VCD back and reducing it to switching-activity figures.

---
 rtl/toggle_pkg.sv | 20 ++
 rtl/toggle_sat_counter.sv | 30 +++
 rtl/toggle_activity_counter.sv | 127 ++++++++++++
 tb/tb_toggle_activity_counter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/toggle_pkg.sv
// Shared types and sizing helpers for the toggle activity counter.
package toggle_pkg;

   typedef enum logic [1:0] {IDLE, PRIME, ACCUM, DRAIN} state_t;

   localparam int NUM_SIG_DEF = 5;
   localparam int CNT_W_DEF   = 16;
   localparam int WIN_W_DEF   = 16;

   // Index width, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // total_toggles width: wide enough to sum NUM_SIG saturated counters.
   function automatic int tot_width(input int cnt_w, input int idx_w);
      return cnt_w + idx_w + 1;
   endfunction

endpackage

// File: rtl/toggle_sat_counter.sv
// Per-net saturating toggle counter.
module toggle_sat_counter
   import toggle_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic             tgl,
   output logic [CNT_W-1:0] cnt,
   output logic             sat_hit,
   output logic             inc
);

   logic full;

   assign full    = &cnt;
   assign sat_hit = en & tgl & full;
   assign inc     = en & tgl & ~full;

   // Count toggles, holding at all-ones once saturated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   cnt <= '0;
      else if (clr) cnt <= '0;
      else if (inc) cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/toggle_activity_counter.sv
// Samples NUM_SIG nets over a window, counts per-net transitions and
// streams the counts out one beat per net over valid/ready.
module toggle_activity_counter
   import toggle_pkg::*;
#(
   parameter int NUM_SIG = NUM_SIG_DEF,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int WIN_W   = WIN_W_DEF,
   parameter int IDX_W   = idx_width(NUM_SIG)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [WIN_W-1:0]             win_len,
   input  logic                         sample_valid,
   input  logic [NUM_SIG-1:0]           sample,
   output logic                         busy,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic [IDX_W-1:0]             res_idx,
   output logic [CNT_W-1:0]             res_count,
   output logic                         res_last,
   output logic [CNT_W+IDX_W:0]         total_toggles,
   output logic                         sat,
   output logic                         done
);

   localparam int TOT_W = tot_width(CNT_W, IDX_W);

   state_t                          state, nxt;
   logic [WIN_W-1:0]                win_q, seen, seen_inc;
   logic [NUM_SIG-1:0]              prev, tgl, inc_v, hit_v;
   logic [NUM_SIG-1:0][CNT_W-1:0]   cnt;
   logic [IDX_W:0]                  npop;
   logic                            accept, acc, beat, last_beat;

   assign accept    = (state == IDLE) && start && (win_len != '0);
   assign acc       = (state == ACCUM) && sample_valid;
   assign tgl       = sample ^ prev;
   assign seen_inc  = seen + 1'b1;
   assign beat      = (state == DRAIN) && res_ready;
   assign last_beat = beat && (res_idx == IDX_W'(NUM_SIG - 1));

   assign busy      = (state != IDLE);
   assign res_valid = (state == DRAIN);
   assign res_last  = res_valid && (res_idx == IDX_W'(NUM_SIG - 1));

   genvar g;
   generate
      for (g = 0; g < NUM_SIG; g++) begin : g_cnt
         toggle_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (accept),
            .en      (acc),
            .tgl     (tgl[g]),
            .cnt     (cnt[g]),
            .sat_hit (hit_v[g]),
            .inc     (inc_v[g])
         );
      end
   endgenerate

   // Number of counters that actually advance this cycle.
   always_comb begin
      npop = '0;
      for (int i = 0; i < NUM_SIG; i++) npop = npop + (IDX_W+1)'(inc_v[i]);
   end

   // Result mux; zero outside DRAIN so idle output is quiet.
   always_comb begin
      res_count = '0;
      for (int i = 0; i < NUM_SIG; i++)
         if (res_valid && (res_idx == IDX_W'(i))) res_count = cnt[i];
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   // Next-state logic.
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:  if (accept) nxt = PRIME;
         PRIME: if (sample_valid) nxt = (win_q == WIN_W'(1)) ? DRAIN : ACCUM;
         ACCUM: if (sample_valid && (seen_inc == win_q)) nxt = DRAIN;
         DRAIN: if (last_beat) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Window bookkeeping, running total, sticky saturation and beat index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q         <= '0;
         seen          <= '0;
         prev          <= '0;
         total_toggles <= '0;
         sat           <= 1'b0;
         res_idx       <= '0;
         done          <= 1'b0;
      end else begin
         done <= last_beat;
         if (accept) begin
            win_q         <= win_len;
            seen          <= '0;
            total_toggles <= '0;
            sat           <= 1'b0;
         end
         if ((state == PRIME) && sample_valid) begin
            prev <= sample;
            seen <= WIN_W'(1);
         end
         if (acc) begin
            prev          <= sample;
            seen          <= seen_inc;
            total_toggles <= total_toggles + TOT_W'(npop);
            if (|hit_v) sat <= 1'b1;
         end
         if (beat) res_idx <= last_beat ? '0 : res_idx + 1'b1;
      end
   end

endmodule

// File: tb/tb_toggle_activity_counter.sv
// Randomized self-checking bench with a window-level reference model.
module tb_toggle_activity_counter;

   localparam int NS = 5;
   localparam int CW = 4;
   localparam int WW = 16;
   localparam int IW = 3;
   localparam int TW = CW + IW + 1;
   localparam int CMAX = (1 << CW) - 1;

   typedef logic [NS-1:0] smp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [WW-1:0] win_len;
   logic          sample_valid;
   smp_t          sample;
   logic          busy, res_valid, res_ready, res_last, sat, done;
   logic [IW-1:0] res_idx;
   logic [CW-1:0] res_count;
   logic [TW-1:0] total_toggles;

   int n_chk = 0;
   int n_fail = 0;

   int m_cnt[NS];
   int m_total;
   int m_sat;

   toggle_activity_counter #(.NUM_SIG(NS), .CNT_W(CW), .WIN_W(WW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
      .sample_valid(sample_valid), .sample(sample), .busy(busy),
      .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx),
      .res_count(res_count), .res_last(res_last),
      .total_toggles(total_toggles), .sat(sat), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d @%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: per-net transition count across the window, clipped.
   task automatic model(input smp_t s[$]);
      m_total = 0;
      m_sat   = 0;
      for (int i = 0; i < NS; i++) begin
         int t;
         t = 0;
         for (int k = 1; k < s.size(); k++) if (s[k][i] != s[k-1][i]) t++;
         m_cnt[i] = (t > CMAX) ? CMAX : t;
         if (t > CMAX) m_sat = 1;
         m_total += m_cnt[i];
      end
   endtask

   // gap: 0 none, 1 three idle cycles before sample 3, 2 random
   // rdy: 0 always, 1 pattern 1,0,0,1, 2 random
   task automatic run_win(input smp_t s[$], input int gap, input int rdy, input bit poke);
      int e, cyc, g;
      bit r;
      model(s);
      win_len = WW'(s.size());
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      for (int k = 0; k < s.size(); k++) begin
         g = (gap == 1 && k == 2) ? 3 : (gap == 2) ? $urandom_range(0, 2) : 0;
         repeat (g) begin
            sample_valid = 1'b0;
            sample = smp_t'($urandom);
            tick();
         end
         if (poke && k == 1) begin
            start = 1'b1;
            win_len = WW'($urandom_range(1, 9));
         end
         sample_valid = 1'b1;
         sample = s[k];
         tick();
         start = 1'b0;
      end
      sample_valid = 1'b0;
      chk("res_valid_latency", res_valid, 1);
      e = 0;
      cyc = 0;
      while (e < NS && cyc < 100) begin
         r = (rdy == 0) ? 1'b1 : (rdy == 1) ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'($urandom_range(0, 1));
         res_ready = r;
         if (poke) begin
            start = 1'b1;
            win_len = WW'($urandom_range(1, 9));
         end
         chk("beat_valid", res_valid, 1);
         chk("beat_idx", res_idx, e);
         chk("beat_count", res_count, m_cnt[e]);
         chk("beat_last", res_last, (e == NS - 1));
         tick();
         if (r) e++;
         cyc++;
      end
      start = 1'b0;
      res_ready = 1'b0;
      chk("beats_total", e, NS);
      chk("done_pulse", done, 1);
      chk("valid_fall", res_valid, 0);
      chk("idle_after", busy, 0);
      chk("total", total_toggles, m_total);
      chk("sat", sat, m_sat);
      tick();
      chk("done_one_cycle", done, 0);
      chk("total_hold", total_toggles, m_total);
      chk("sat_hold", sat, m_sat);
      chk("stay_idle", busy, 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_valid"}, res_valid, 0);
      chk({tag, "_idx"}, res_idx, 0);
      chk({tag, "_count"}, res_count, 0);
      chk({tag, "_last"}, res_last, 0);
      chk({tag, "_total"}, total_toggles, 0);
      chk({tag, "_sat"}, sat, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   initial begin
      smp_t fa[$], q[$];
      rst_n = 1'b0;
      start = 1'b0;
      win_len = '0;
      sample_valid = 1'b0;
      sample = '0;
      res_ready = 1'b0;
      #12;
      chk_zero("reset");
      rst_n = 1'b1;
      tick();

      fa = '{5'b01010, 5'b10110, 5'b10110, 5'b01010, 5'b11111, 5'b01001, 5'b00000};
      run_win(fa, 0, 0, 1'b0);
      run_win(fa, 1, 1, 1'b0);

      // Net a toggles every sample: 20 transitions saturate a 4-bit counter.
      q = {};
      for (int k = 0; k < 21; k++) q.push_back(smp_t'(k % 2));
      run_win(q, 0, 0, 1'b0);

      // Zero-length start is ignored; previous results persist.
      win_len = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("win0_busy", busy, 0);
      tick();
      chk("win0_busy_later", busy, 0);
      chk("win0_total_hold", total_toggles, m_total);
      chk("win0_sat_hold", sat, m_sat);

      q = {smp_t'($urandom)};
      run_win(q, 0, 0, 1'b0);

      run_win(fa, 0, 2, 1'b1);

      // Asynchronous reset mid-window.
      win_len = WW'(10);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sample_valid = 1'b1;
         sample = (k % 2) ? 5'b11111 : 5'b00000;
         tick();
      end
      sample_valid = 1'b0;
      chk("pre_reset_total", total_toggles, 10);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("async_reset");
      #2;
      rst_n = 1'b1;
      tick();
      run_win(fa, 0, 0, 1'b0);

      for (int n = 0; n < 15; n++) begin
         int len;
         len = $urandom_range(1, 24);
         q = {};
         for (int k = 0; k < len; k++) q.push_back(smp_t'($urandom));
         run_win(q, 2, 2, 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
